divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 154 +++++++++++++++
 tb/tb_divider_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Multi-cycle restoring radix-2 divider with signed/unsigned quotient and remainder ops.
// state | meaning:  IDLE accept request | CALC one quotient bit per cycle | FIX sign correction | DONE result held
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_signed, in_dvd_neg, in_dvs_neg;
  logic [WIDTH-1:0] in_dvd_mag, in_dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Ready is also masked by reset so every output reads zero while rst_n is low.
  assign in_ready  = (state_q == IDLE) && !flush && rst_n;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  assign in_signed  = ~op[0];
  assign in_dvd_neg = in_signed & dividend[WIDTH-1];
  assign in_dvs_neg = in_signed & divisor[WIDTH-1];
  assign in_dvd_mag = in_dvd_neg ? -dividend : dividend;
  assign in_dvs_mag = in_dvs_neg ? -divisor : divisor;

  // Trial subtraction is one bit wider so a full-range unsigned divisor cannot overflow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag_q};

  assign quo_fix = (~op_q[0] & (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
  assign rem_fix = (~op_q[0] & dvd_neg_q) ? -rem_q : rem_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    dvs_mag_d   = dvs_mag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d      = op;
          dvd_neg_d = in_dvd_neg;
          dvs_neg_d = in_dvs_neg;
          dvs_mag_d = in_dvs_mag;
          if (divisor == '0) begin
            result_d    = op[1] ? dividend : ALL_ONES;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (in_signed && dividend == MIN_NEG && divisor == ALL_ONES) begin
            result_d    = op[1] ? '0 : MIN_NEG;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = in_dvd_mag;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        result_d    = op_q[1] ? rem_fix : quo_fix;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          result_d    = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      result_d    = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed-vector bench for divider_unit at WIDTH=32 with hand-computed results.
module tb_divider_unit;

  localparam int W = 32;
  localparam int LAT_NORM = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;

  int n_total = 0;
  int n_pass  = 0;

  divider_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request, measure latency to out_valid, optionally stall, then consume.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input int hold);
    int lat;
    logic leak;
    logic [31:0] held;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    leak = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (result != '0 || in_ready) leak = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_busy"}, 32'(leak), 32'd0);
    held = result;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_res"}, result, held);
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_res_clr"}, result, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    #3;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, LAT_NORM, 32'd14, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, LAT_NORM, 32'd2, 0);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, LAT_NORM, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, LAT_NORM, 32'hFFFF_FFFF, 0);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, LAT_NORM, 32'd1, 0);
    run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, LAT_NORM, 32'hFFFF_FFFD, 0);
    run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, LAT_NORM, 32'd14, 0);
    run_op("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, LAT_NORM, 32'hFFFF_FFFE, 0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, LAT_NORM, 32'hFFFF_FFFF, 0);
    run_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, LAT_NORM, 32'd0, 0);
    run_op("remu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, LAT_NORM, 32'h8000_0000, 0);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 1, 32'd5, 0);
    run_op("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 0);
    run_op("divu_stall", 2'b01, 32'd1000, 32'd10, LAT_NORM, 32'd100, 5);

    // Flush during CALC step 10.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_rdy_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_rdy", 32'(in_ready), 32'd1);
    chk("flush_ov", 32'(out_valid), 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", 32'(seen), 32'd0);
    end
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, LAT_NORM, 32'd3, 0);

    // Flush beats accept in IDLE.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
    #1 chk("flush_idle_rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush_idle_noacc", 32'(in_ready), 32'd1);

    // Flush beats consume in DONE.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush_done_ov", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; out_ready = 1'b0; end
    @(negedge clk);
    chk("flush_done_clr", 32'(out_valid), 32'd0);
    chk("flush_done_res", result, 32'd0);
    chk("flush_done_rdy", 32'(in_ready), 32'd1);

    // Reset asserted during CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", 32'(out_valid), 32'd0);
    chk("rst_mid_res", result, 32'd0);
    chk("rst_mid_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_rdy", 32'(in_ready), 32'd1);
    begin
      logic stale;
      stale = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid || result != '0) stale = 1'b1;
      end
      chk("rst_no_stale", 32'(stale), 32'd0);
    end
    run_op("remu_after_rst", 2'b11, 32'd100, 32'd7, LAT_NORM, 32'd2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
